// File: rtl/clk_branch_seq.sv
// rtl/clk_branch_seq.sv - staggered thermometer enable sequencer for a bank of gated clock branches
// Optional test/scan bypass input byp is added when CLK_BRANCH_SEQ_BYPASS_EN is defined.
module clk_branch_seq #(
   parameter  int NBR     = 4,
   parameter  int STAGGER = 4,
   parameter  int TW      = 8,
   localparam int LW      = $clog2(NBR + 1)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           req,
`ifdef CLK_BRANCH_SEQ_BYPASS_EN
   input  logic           byp,
`endif
   output logic [NBR-1:0] en,
   output logic [LW-1:0]  lvl,
   output logic           ack,
   output logic           busy
);

   localparam logic [LW-1:0] LVL_MAX = LW'(NBR);
   localparam logic [TW-1:0] RELOAD  = TW'(STAGGER - 1);

   logic [LW-1:0]  seq_lvl, seq_lvl_nx;
   logic [TW-1:0]  timer, timer_nx;
   logic [NBR-1:0] en_nx;
   logic [LW-1:0]  lvl_nx;
   logic           ack_nx;
   logic           byp_i;

`ifdef CLK_BRANCH_SEQ_BYPASS_EN
   assign byp_i = byp;
`else
   assign byp_i = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         seq_lvl <= '0;
         timer   <= '0;
         en      <= '0;
         lvl     <= '0;
         ack     <= 1'b0;
      end else begin
         seq_lvl <= seq_lvl_nx;
         timer   <= timer_nx;
         en      <= en_nx;
         lvl     <= lvl_nx;
         ack     <= ack_nx;
      end
   end

   // Outputs are a registered decode of seq_lvl, so they trail it by one cycle.
   always_comb begin
      seq_lvl_nx = seq_lvl;
      timer_nx   = timer;
      if (timer != '0) begin
         timer_nx = timer - TW'(1);
      end else if (req && (seq_lvl != LVL_MAX)) begin
         seq_lvl_nx = seq_lvl + LW'(1);
         timer_nx   = RELOAD;
      end else if (!req && (seq_lvl != '0)) begin
         seq_lvl_nx = seq_lvl - LW'(1);
         timer_nx   = RELOAD;
      end

      for (int i = 0; i < NBR; i++) begin
         en_nx[i] = (LW'(i) < seq_lvl);
      end
      lvl_nx = seq_lvl;
      ack_nx = (seq_lvl == LVL_MAX);

      // Bypass forces fully on immediately; the reloaded timer spaces the first step down.
      if (byp_i) begin
         seq_lvl_nx = LVL_MAX;
         timer_nx   = RELOAD;
         en_nx      = '1;
         lvl_nx     = LVL_MAX;
         ack_nx     = 1'b1;
      end
   end

   always_comb begin
      busy = req ? (lvl != LVL_MAX) : (lvl != '0);
   end

endmodule
